// File: rtl/mul_arb_pkg.sv
// Shared types and sizing for the two-port shift-add multiplier arbiter.
package mul_arb_pkg;

    localparam int OP_W   = 8;
    localparam int RES_W  = 16;
    localparam int N_ITER = 8;
    localparam int CNT_W  = $clog2(N_ITER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/shift_add_mul8.sv
// Sequential 8x8 unsigned multiplier: one multiplier bit per cycle, LSB first.
module shift_add_mul8
    import mul_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] p,
    output logic             done
);

    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] term;

    // p is the accumulator value after the current iteration, so the
    // final product is visible in the same cycle that done is raised.
    assign term = op_b[cnt] ? (RES_W'(op_a) << cnt) : '0;
    assign p    = acc + term;
    assign done = run && (cnt == CNT_W'(N_ITER - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run  <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            op_a <= '0;
            op_b <= '0;
        end else if (start) begin
            run  <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
            op_a <= a;
            op_b <= b;
        end else if (run) begin
            acc <= p;
            cnt <= cnt + 1'b1;
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between two ports.
module mul_arbiter
    import mul_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [OP_W-1:0]  a0,
    input  logic [OP_W-1:0]  b0,
    output logic             ack0,
    output logic             done0,
    output logic [RES_W-1:0] res0,
    input  logic             req1,
    input  logic [OP_W-1:0]  a1,
    input  logic [OP_W-1:0]  b1,
    output logic             ack1,
    output logic             done1,
    output logic [RES_W-1:0] res1,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             winner;
    logic             owner;
    logic             last;
    logic             start;
    logic             mul_done;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic [RES_W-1:0] prod;

    shift_add_mul8 u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (op_a),
        .b     (op_b),
        .p     (prod),
        .done  (mul_done)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // On a tie the port not served last wins.
        winner    = (req0 && req1) ? ~last : req1;
        op_a      = winner ? a1 : a0;
        op_b      = winner ? b1 : b0;
        start     = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (mul_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            res0  <= '0;
            res1  <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            ack0  <= start && !winner;
            ack1  <= start && winner;
            done0 <= mul_done && !owner;
            done1 <= mul_done && owner;
            if (start) begin
                owner <= winner;
                last  <= winner;
            end
            if (mul_done && !owner) begin
                res0 <= prod;
            end
            if (mul_done && owner) begin
                res1 <= prod;
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench: transaction-level model plus directed literal checks.
module tb_mul_arbiter;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [7:0]  a0   = '0;
    logic [7:0]  b0   = '0;
    logic [7:0]  a1   = '0;
    logic [7:0]  b1   = '0;
    logic        ack0, done0, ack1, done1, busy;
    logic [15:0] res0, res1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mul_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .ack0  (ack0),
        .done0 (done0),
        .res0  (res0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .ack1  (ack1),
        .done1 (done1),
        .res1  (res1),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Transaction model: 'since' counts cycles after the grant edge.
    // Grant cycle 1 carries ack, cycle 9 carries done + new res,
    // cycle 10 is idle again and may grant.
    int          since = 0;
    int          who   = 0;
    bit          last1 = 1'b1;
    logic [15:0] m_res [2] = '{16'h0, 16'h0};
    logic [15:0] m_prod = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            since    = 0;
            last1    = 1'b1;
            m_res[0] = '0;
            m_res[1] = '0;
        end else if (since == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) who = last1 ? 0 : 1;
                else              who = req0 ? 0 : 1;
                if (who == 0) m_prod = 16'(a0) * 16'(b0);
                else          m_prod = 16'(a1) * 16'(b1);
                last1 = (who == 1);
                since = 1;
            end
        end else if (since == 9) begin
            since = 0;
        end else begin
            since = since + 1;
            if (since == 9) m_res[who] = m_prod;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [36:0] e, g;
            e = {since != 0,
                 since == 1 && who == 0, since == 1 && who == 1,
                 since == 9 && who == 0, since == 9 && who == 1,
                 m_res[0], m_res[1]};
            g = {busy, ack0, ack1, done0, done1, res0, res1};
            check("cycle", 64'(g), 64'(e));
        end
    end

    function automatic logic ack_of(int p);
        return p != 0 ? ack1 : ack0;
    endfunction

    function automatic logic done_of(int p);
        return p != 0 ? done1 : done0;
    endfunction

    function automatic logic [15:0] res_of(int p);
        return p != 0 ? res1 : res0;
    endfunction

    task automatic drive(int p, logic r, logic [7:0] a, logic [7:0] b);
        if (p == 0) begin req0 = r; a0 = a; b0 = b; end
        else        begin req1 = r; a1 = a; b1 = b; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        check("reset_outs", 64'({busy, ack0, ack1, done0, done1, res0, res1}), 64'h0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic single(int p, logic [7:0] a, logic [7:0] b,
                          logic [15:0] exp, logic [15:0] exp_other);
        int ack_at = -1;
        int done_at = -1;
        @(negedge clk);
        #1;
        drive(p, 1'b1, a, b);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            #1;
            if (ack_of(p) && ack_at < 0) begin
                ack_at = n;
                drive(p, 1'b0, 8'($urandom), 8'($urandom));
            end
            if (done_of(p) && done_at < 0) done_at = n;
            drive(1 - p, 1'b0, 8'($urandom), 8'($urandom));
        end
        check($sformatf("ack_lat_p%0d", p), 64'(ack_at), 64'd1);
        check($sformatf("done_lat_p%0d", p), 64'(done_at), 64'd9);
        check($sformatf("res_p%0d_%0dx%0d", p, a, b), 64'(res_of(p)), 64'(exp));
        check($sformatf("res_other_p%0d", 1 - p), 64'(res_of(1 - p)), 64'(exp_other));
    endtask

    initial begin
        int order[$];
        int t_ack[2];
        int t_done[2];
        int n_done;

        #1;
        rst = 1'b1;
        chk_en = 1'b1;
        do_reset();

        single(0, 8'd3, 8'd5, 16'd15, 16'd0);

        do_reset();
        @(negedge clk);
        #1;
        drive(0, 1'b1, 8'd7, 8'd9);
        drive(1, 1'b1, 8'd12, 8'd12);
        t_ack = '{-1, -1};
        t_done = '{-1, -1};
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p)) begin
                    order.push_back(p);
                    t_ack[p] = n;
                    if (p == 0) req0 = 1'b0;
                    else        req1 = 1'b0;
                end
                if (done_of(p)) t_done[p] = n;
            end
        end
        check("sim_order_n", 64'(order.size()), 64'd2);
        check("sim_first", 64'(order.size() > 0 ? order[0] : -1), 64'd0);
        check("sim_ack0", 64'(t_ack[0]), 64'd1);
        check("sim_done0", 64'(t_done[0]), 64'd9);
        check("sim_ack1", 64'(t_ack[1]), 64'd11);
        check("sim_done1", 64'(t_done[1]), 64'd19);
        check("sim_res0", 64'(res0), 64'd63);
        check("sim_res1", 64'(res1), 64'd144);

        order.delete();
        @(negedge clk);
        #1;
        drive(0, 1'b1, 8'd10, 8'd11);
        drive(1, 1'b1, 8'd20, 8'd21);
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            #1;
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
            if (order.size() >= 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        check("fair_n", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fair_grant%0d", i),
                  64'(i < order.size() ? order[i] : -1), 64'(i % 2));
        end
        check("fair_res0", 64'(res0), 64'd110);
        check("fair_res1", 64'(res1), 64'd420);

        single(1, 8'd255, 8'd255, 16'hFE01, 16'd110);
        single(0, 8'd0, 8'd200, 16'd0, 16'hFE01);
        single(1, 8'd200, 8'd0, 16'd0, 16'd0);
        single(0, 8'd255, 8'd1, 16'd255, 16'd0);

        @(negedge clk);
        #1;
        drive(0, 1'b1, 8'd13, 8'd17);
        repeat (5) @(negedge clk);
        #1;
        check("mid_run_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        check("abort_outs", 64'({busy, ack0, ack1, done0, done1, res0, res1}), 64'h0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        n_done = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            #1;
            if (done0 || done1) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        single(0, 8'd13, 8'd17, 16'd221, 16'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset; asynchronous, active-high.
REQ-003 req0  in  1  port-0 multiply request; held high with operands stable until ack0.
REQ-004 a0, b0  in  8 each  port-0 unsigned operands.
REQ-005 ack0  out  1  one-cycle pulse: port-0 operands captured.
REQ-006 done0  out  1  one-cycle pulse: res0 updated with the port-0 product.
REQ-007 res0  out  16  port-0 product; holds until the next port-0 completion.
REQ-008 req1, a1, b1, ack1, done1, res1  same widths and meanings for port 1.
REQ-009 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE.
REQ-011 IDLE -> RUN at the edge where any req is sampled high.
  - Winner's operands latched; winner's ack pulsed in the following cycle; iteration counter cleared.
REQ-012 Arbitration SHALL be round-robin via a last-served pointer.
  - Only one req high: that port wins.
  - Both high: the port not last served wins.
  - Pointer after reset favours port 0.
REQ-013 RUN SHALL process exactly one multiplier bit per cycle, LSB first, for 8 cycles.
  - Each cycle adds (a << i) to a 16-bit accumulator when b[i]=1.
  - No early termination for zero operands.
REQ-014 RUN -> DONE after the 8th iteration: winner's res loaded with the full 16-bit product and winner's done pulsed for that one DONE cycle.
REQ-015 DONE -> IDLE unconditionally after one cycle.
REQ-016 Latency and throughput:
  - req sampled at edge T: ack at cycle T+1, done at cycle T+9.
  - Next ack earliest at T+11, giving one product per 10 cycles.
REQ-017 Products SHALL be exact for all 8-bit unsigned operands: max 255*255 = 0xFE01, no truncation.
REQ-018 req changes and the losing port's operands during RUN/DONE SHALL NOT affect the computation in progress.
REQ-019 A req still high in IDLE after its own done SHALL be treated as a new request.
REQ-020 ack and done SHALL never be asserted for both ports in the same cycle.
REQ-021 The other port's res SHALL be unchanged by a completion.

Reset
REQ-022 On rst, without waiting for clk:
  - FSM -> IDLE; counter, accumulator and latched operands -> 0.
  - Pointer -> favour port 0.
  - ack0/1, done0/1 and busy -> 0; res0/1 -> 0.
REQ-023 rst asserted mid-RUN SHALL abort the operation with no done pulse; the request is not completed.
REQ-024 First grant is possible at the first clk edge after rst deasserts.

Structure
REQ-025 Shared package mul_arb_pkg SHALL hold:
  - the state enum;
  - OP_W=8, RES_W=16, N_ITER=8.
REQ-026 The shift-add datapath SHALL be a sub-module, shift_add_mul8.
  - Ports: clk, rst, start, a, b, p[15:0], done.
  - mul_arbiter holds the FSM, arbitration and per-port result registers.

Verification
REQ-027 Single request: req0 with a0=3, b0=5 sampled at T -> ack0 at T+1, done0 at T+9, res0=15; res1 stays 0.
REQ-028 Simultaneous requests after reset: req0 (7x9) and req1 (12x12) both held high.
  - Expect ack0 then done0 with res0=63.
  - Then ack1 then done1 with res1=144.
REQ-029 Fairness: both reqs held high continuously for 4 products -> grants alternate 0,1,0,1.
REQ-030 Boundary operands:
  - 255x255 -> res=0xFE01.
  - 0x200 and 200x0 -> res=0 with full 10-cycle timing.
REQ-031 Reset mid-RUN: rst pulsed during iteration 4 -> no done, all outputs 0, busy 0; the next request completes correctly.
